// File: rtl/ppc_fetch_pkg.sv
// Shared types for the PPC instruction-fetch front end.
package ppc_fetch_pkg;
  localparam int INST_W = 32;
  localparam int DW_W   = 64;
  localparam int ADDR_W = 61;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [0:INST_W-1] inst;
    logic [0:DW_W-1]   pc;
  } fq_entry_t;
endpackage

// File: rtl/ppc_inst_fifo.sv
// DEPTH-entry instruction queue: 0/1/2 pushes and one pop per cycle, sync flush.
module ppc_inst_fifo
  import ppc_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  fq_entry_t [1:0]          push_data,
  input  logic                     pop,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  fq_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [PW:0]           count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Caller guarantees room for push_cnt after this cycle's pop.
      for (int i = 0; i < 2; i++)
        if (push_cnt > 2'(i)) mem_d[tail_q + PW'(i)] = push_data[i];
      tail_d  = tail_q + PW'(push_cnt);
      head_d  = head_q + PW'(pop);
      count_d = count_q + (PW+1)'(push_cnt) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/ppc_fetch_queue.sv
// Fetch PC, RUN/HALTED control and doubleword split feeding ppc_inst_fifo.
// Optional counters stat_fetched/stat_stalls under FETCH_STATS_EN.
module ppc_fetch_queue
  import ppc_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [0:63] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [0:60]   readAddr,
  input  logic [0:63]   readData,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [0:31]   inst,
  output logic [0:63]   inst_pc,
  input  logic          redirect_valid,
  input  logic [0:63]   redirect_pc,
  input  logic          halt,
  output logic          busy
`ifdef FETCH_STATS_EN
  ,
  output logic [0:31]   stat_fetched,
  output logic [0:31]   stat_stalls
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q;
  logic [0:63]     fpc_q, fpc_d;
  logic [CW-1:0]   count, free_slots;
  fq_entry_t       head, w0, w1;
  fq_entry_t [1:0] push_data;
  logic [1:0]      need, push_cnt;
  logic            pop, fetch_en;
  logic            unused_rpc;

  assign unused_rpc = ^redirect_pc[62:63];

  assign readAddr   = fpc_q[0:60];
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign busy       = (state_q == RUN) || inst_valid;

  assign need       = fpc_q[61] ? 2'd1 : 2'd2;
  // A same-cycle pop frees its slot for this cycle's fetch.
  assign free_slots = CW'(DEPTH) - (count - CW'(pop));
  assign fetch_en   = (state_q == RUN) && !halt && !redirect_valid;
  assign w0         = '{inst: readData[0:31],  pc: fpc_q};
  assign w1         = '{inst: readData[32:63], pc: {fpc_q[0:60], 3'b100}};

  always_comb begin
    push_cnt  = 2'd0;
    push_data = '0;
    fpc_d     = fpc_q;
    if (redirect_valid) begin
      fpc_d = {redirect_pc[0:61], 2'b00};
    end else if (fetch_en && free_slots >= CW'(need)) begin
      push_cnt = need;
      if (fpc_q[61]) begin
        push_data[0] = w1;
      end else begin
        push_data[0] = w0;
        push_data[1] = w1;
      end
      fpc_d = {fpc_q[0:60] + 61'd1, 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           state_q <= RUN;
    else if (redirect_valid)              state_q <= RUN;
    else if (state_q == RUN && halt)      state_q <= HALTED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fpc_q <= RESET_PC;
    else        fpc_q <= fpc_d;
  end

  ppc_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef FETCH_STATS_EN
  logic [0:31] fetched_q, fetched_d, stalls_q, stalls_d;
  logic [32:0] fetched_sum;

  always_comb begin
    fetched_sum = {1'b0, fetched_q} + 33'(push_cnt);
    fetched_d   = fetched_sum[32] ? '1 : fetched_sum[31:0];
    stalls_d    = stalls_q;
    if (state_q == RUN && !redirect_valid && push_cnt == 2'd0 && stalls_q != '1)
      stalls_d = stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_stalls  = stalls_q;
`endif
endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Directed bench for ppc_fetch_queue with a combinational memory model.
module tb_ppc_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:60] readAddr;
  logic [0:63] readData;
  logic        inst_valid, inst_ready;
  logic [0:31] inst;
  logic [0:63] inst_pc;
  logic        redirect_valid;
  logic [0:63] redirect_pc;
  logic        halt, busy;
`ifdef FETCH_STATS_EN
  logic [0:31] stat_fetched, stat_stalls;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ppc_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .readAddr       (readAddr),
    .readData       (readData),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .busy           (busy)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_stalls    (stat_stalls)
`endif
  );

  // Word at byte address a is tagged with its low address bits.
  function automatic logic [0:31] wfn(input logic [0:63] a);
    return {16'hC0DE, a[48:63]};
  endfunction

  assign readData = {wfn({readAddr, 3'b000}), wfn({readAddr, 3'b100})};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = rdy;
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else passed++;
    total++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst); else passed++;
    total++; if (inst_pc !== 64'h0) $display("FAIL reset_pc: got %h want 0", inst_pc); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else passed++;
    total++; if (readAddr !== 61'h0) $display("FAIL reset_addr: got %h want 0", readAddr); else passed++;
  endtask

  task automatic test_stream;
    logic [0:63] pc;
    for (int i = 0; i < 8; i++) begin
      step;
      pc = 64'(4 * i);
      total++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, pc, wfn(pc)})
        $display("FAIL stream[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, inst_valid, inst_pc, inst, pc, wfn(pc));
      else passed++;
    end
  endtask

  task automatic test_full;
    logic [0:63] pc;
    do_reset(1'b0);
    repeat (10) step;
    total++; if (readAddr !== 61'd2) $display("FAIL full_addr: got %h want 2", readAddr); else passed++;
    total++; if ({inst_valid, inst_pc} !== {1'b1, 64'h0}) $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); else passed++;
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 64'(4 * i);
      total++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, pc, wfn(pc)})
        $display("FAIL full_drain[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h", i, inst_valid, inst_pc, inst, pc);
      else passed++;
      step;
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    repeat (3) step;
    inst_ready = 1'b1;
    step;
    inst_ready = 1'b0;
    total++; if ({inst_valid, inst_pc} !== {1'b1, 64'h4}) $display("FAIL redir_pre: got v=%b pc=%h want v=1 pc=4", inst_valid, inst_pc); else passed++;
    redirect_valid = 1'b1; redirect_pc = 64'h104;
    step;
    redirect_valid = 1'b0;
    total++; if ({inst_valid, readAddr} !== {1'b0, 61'h20}) $display("FAIL redir_flush: got v=%b addr=%h want v=0 addr=20", inst_valid, readAddr); else passed++;
    step;
    total++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h104, wfn(64'h104)})
      $display("FAIL redir_first: got v=%b pc=%h i=%h want v=1 pc=104 i=%h", inst_valid, inst_pc, inst, wfn(64'h104));
    else passed++;
    inst_ready = 1'b1;
    step;
    inst_ready = 1'b0;
    total++; if ({inst_valid, inst_pc} !== {1'b1, 64'h108}) $display("FAIL redir_second: got v=%b pc=%h want v=1 pc=108", inst_valid, inst_pc); else passed++;
  endtask

  task automatic test_halt_redirect;
    redirect_valid = 1'b1; halt = 1'b1; redirect_pc = 64'h43;
    step;
    redirect_valid = 1'b0; halt = 1'b0;
    total++; if ({busy, inst_valid} !== 2'b10) $display("FAIL hr_state: got busy=%b v=%b want busy=1 v=0", busy, inst_valid); else passed++;
    step;
    total++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h40, wfn(64'h40)})
      $display("FAIL hr_first: got v=%b pc=%h i=%h want v=1 pc=40", inst_valid, inst_pc, inst);
    else passed++;
  endtask

  task automatic test_halt_drain;
    do_reset(1'b0);
    step;
    halt = 1'b1;
    step;
    total++; if ({inst_valid, inst_pc, busy} !== {1'b1, 64'h0, 1'b1}) $display("FAIL halt_head0: got v=%b pc=%h busy=%b want v=1 pc=0 busy=1", inst_valid, inst_pc, busy); else passed++;
    inst_ready = 1'b1;
    step;
    total++; if ({inst_valid, inst_pc} !== {1'b1, 64'h4}) $display("FAIL halt_head1: got v=%b pc=%h want v=1 pc=4", inst_valid, inst_pc); else passed++;
    step;
    total++; if ({inst_valid, busy, readAddr} !== {2'b00, 61'd1}) $display("FAIL halt_idle: got v=%b busy=%b addr=%h want 0 0 1", inst_valid, busy, readAddr); else passed++;
    step;
    total++; if ({inst_valid, busy, readAddr} !== {2'b00, 61'd1}) $display("FAIL halt_nofetch: got v=%b busy=%b addr=%h want 0 0 1", inst_valid, busy, readAddr); else passed++;
    redirect_valid = 1'b1; redirect_pc = 64'h0; halt = 1'b0;
    step;
    redirect_valid = 1'b0;
    total++; if ({busy, inst_valid} !== 2'b10) $display("FAIL halt_resume: got busy=%b v=%b want busy=1 v=0", busy, inst_valid); else passed++;
    step;
    total++; if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h0, wfn(64'h0)}) $display("FAIL halt_refetch: got v=%b pc=%h i=%h want v=1 pc=0", inst_valid, inst_pc, inst); else passed++;
  endtask

  task automatic test_wrap;
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step;
    redirect_valid = 1'b0;
    total++; if (inst_valid !== 1'b0) $display("FAIL wrap_flush: got v=%b want 0", inst_valid); else passed++;
    step;
    total++;
    if ({inst_valid, inst_pc, readAddr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 61'd0})
      $display("FAIL wrap_last: got v=%b pc=%h addr=%h want v=1 pc=fffffffffffffffc addr=0", inst_valid, inst_pc, readAddr);
    else passed++;
    step;
    total++; if ({inst_valid, inst_pc} !== {1'b1, 64'h0}) $display("FAIL wrap_zero: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); else passed++;
    inst_ready = 1'b0;
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats;
    do_reset(1'b0);
    repeat (5) step;
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    step;
    redirect_valid = 1'b0;
    step;
    total++; if (stat_fetched !== 32'd6) $display("FAIL stat_fetched: got %0d want 6", stat_fetched); else passed++;
    total++; if (stat_stalls !== 32'd3) $display("FAIL stat_stalls: got %0d want 3", stat_stalls); else passed++;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    total++; if ({stat_fetched, stat_stalls} !== 64'h0) $display("FAIL stat_clear: got %0d/%0d want 0/0", stat_fetched, stat_stalls); else passed++;
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_redirect;
    test_halt_redirect;
    test_halt_drain;
    test_wrap;
`ifdef FETCH_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
